// File: rtl/pipeline_id_idex_if.sv
// Bundle between fetch/writeback and the ID stage: IF/ID bus, WB port, hazard and
// jump controls back to fetch, and the ID/EX register outputs.
interface pipeline_id_idex_if;
    logic [63:0] IFID;
    logic        WBRegWrite;
    logic [4:0]  WBRd;
    logic [31:0] WBData;
    logic        Flush;

    logic        PCWrite;
    logic        IFIDWrite;
    logic        Stall;
    logic        IFFlush;
    logic [2:0]  PCSrc;
    logic [25:0] JT;
    logic [31:0] DatabusA;

    logic [31:0] IDEX_PC4;
    logic [31:0] IDEX_A;
    logic [31:0] IDEX_B;
    logic [31:0] IDEX_Imm;
    logic [4:0]  IDEX_Shamt;
    logic [4:0]  IDEX_Rs;
    logic [4:0]  IDEX_Rt;
    logic [4:0]  IDEX_Rd;
    logic [15:0] IDEX_Ctrl;

    modport master (
        output IFID, WBRegWrite, WBRd, WBData, Flush,
        input  PCWrite, IFIDWrite, Stall, IFFlush, PCSrc, JT, DatabusA,
        input  IDEX_PC4, IDEX_A, IDEX_B, IDEX_Imm,
        input  IDEX_Shamt, IDEX_Rs, IDEX_Rt, IDEX_Rd, IDEX_Ctrl
    );

    modport slave (
        input  IFID, WBRegWrite, WBRd, WBData, Flush,
        output PCWrite, IFIDWrite, Stall, IFFlush, PCSrc, JT, DatabusA,
        output IDEX_PC4, IDEX_A, IDEX_B, IDEX_Imm,
        output IDEX_Shamt, IDEX_Rs, IDEX_Rt, IDEX_Rd, IDEX_Ctrl
    );
endinterface

// File: rtl/pipeline_id_idex.sv
// MIPS ID stage with register file, load-use hazard unit, jump resolution and ID/EX register.
// Optional macro PIPE_WB_BYPASS_EN: same-cycle WB write is visible on register reads.
module pipeline_id_idex #(
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned IMEM_MSB = 8
) (
    input  logic                clk,
    input  logic                reset,
    pipeline_id_idex_if.slave   bus_io
);

    localparam logic [5:0] OpR      = 6'h00;
    localparam logic [5:0] OpRegimm = 6'h01;
    localparam logic [5:0] OpJ      = 6'h02;
    localparam logic [5:0] OpJal    = 6'h03;
    localparam logic [5:0] OpBeq    = 6'h04;
    localparam logic [5:0] OpBne    = 6'h05;
    localparam logic [5:0] OpBlez   = 6'h06;
    localparam logic [5:0] OpBgtz   = 6'h07;
    localparam logic [5:0] OpAddi   = 6'h08;
    localparam logic [5:0] OpAddiu  = 6'h09;
    localparam logic [5:0] OpSlti   = 6'h0A;
    localparam logic [5:0] OpSltiu  = 6'h0B;
    localparam logic [5:0] OpAndi   = 6'h0C;
    localparam logic [5:0] OpOri    = 6'h0D;
    localparam logic [5:0] OpLui    = 6'h0F;
    localparam logic [5:0] OpLw     = 6'h23;
    localparam logic [5:0] OpSw     = 6'h2B;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnJalr = 6'h09;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSltu = 6'h2B;

    // ALU operation codes; zero is reserved so a bubble never selects an ALU op.
    localparam logic [4:0] AluAdd  = 5'd1;
    localparam logic [4:0] AluAddu = 5'd2;
    localparam logic [4:0] AluSub  = 5'd3;
    localparam logic [4:0] AluSubu = 5'd4;
    localparam logic [4:0] AluAnd  = 5'd5;
    localparam logic [4:0] AluOr   = 5'd6;
    localparam logic [4:0] AluXor  = 5'd7;
    localparam logic [4:0] AluNor  = 5'd8;
    localparam logic [4:0] AluSlt  = 5'd9;
    localparam logic [4:0] AluSltu = 5'd10;
    localparam logic [4:0] AluSll  = 5'd11;
    localparam logic [4:0] AluSrl  = 5'd12;
    localparam logic [4:0] AluSra  = 5'd13;
    localparam logic [4:0] AluLui  = 5'd14;

    localparam logic [2:0] BrNone = 3'd0;
    localparam logic [2:0] BrEq   = 3'd1;
    localparam logic [2:0] BrNe   = 3'd2;
    localparam logic [2:0] BrLez  = 3'd3;
    localparam logic [2:0] BrGtz  = 3'd4;
    localparam logic [2:0] BrLtz  = 3'd5;

    localparam logic [2:0] PcSrcSeq  = 3'd0;
    localparam logic [2:0] PcSrcJt   = 3'd2;
    localparam logic [2:0] PcSrcReg  = 3'd3;

    logic [31:0] instr;
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;

    assign pc4   = bus_io.IFID[63:32];
    assign instr = bus_io.IFID[31:0];
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm16 = instr[15:0];

    // Register file.
    logic [31:0] rf_q [RF_DEPTH];
    logic        wb_we;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;

    assign wb_we = bus_io.WBRegWrite && (bus_io.WBRd != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we) begin
            rf_q[bus_io.WBRd] <= bus_io.WBData;
        end
    end

    always_comb begin
        rdata_a = rf_q[rs];
        rdata_b = rf_q[rt];
`ifdef PIPE_WB_BYPASS_EN
        if (wb_we && (bus_io.WBRd == rs)) rdata_a = bus_io.WBData;
        if (wb_we && (bus_io.WBRd == rt)) rdata_b = bus_io.WBData;
`endif
    end

    // Instruction decode.
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       link_pc4;
    logic       alu_src_shamt;
    logic       alu_src_imm;
    logic       branch;
    logic [2:0] br_cond;
    logic [4:0] alu_op;
    logic       rt_read;
    logic       jump_imm;
    logic       jump_reg;
    logic       imm_zext;
    logic       imm_lui;
    logic [4:0] dst_d;

    always_comb begin
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        link_pc4      = 1'b0;
        alu_src_shamt = 1'b0;
        alu_src_imm   = 1'b0;
        branch        = 1'b0;
        br_cond       = BrNone;
        alu_op        = 5'd0;
        rt_read       = 1'b0;
        jump_imm      = 1'b0;
        jump_reg      = 1'b0;
        imm_zext      = 1'b0;
        imm_lui       = 1'b0;
        dst_d         = rt;

        case (op)
            OpR: begin
                dst_d = rd;
                case (funct)
                    FnSll, FnSrl, FnSra: begin
                        reg_write     = 1'b1;
                        alu_src_shamt = 1'b1;
                        rt_read       = 1'b1;
                        alu_op        = (funct == FnSll) ? AluSll :
                                        (funct == FnSrl) ? AluSrl : AluSra;
                    end
                    FnJr: jump_reg = 1'b1;
                    FnJalr: begin
                        jump_reg  = 1'b1;
                        reg_write = 1'b1;
                        link_pc4  = 1'b1;
                    end
                    FnAdd:  begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluAdd;  end
                    FnAddu: begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluAddu; end
                    FnSub:  begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluSub;  end
                    FnSubu: begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluSubu; end
                    FnAnd:  begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluAnd;  end
                    FnOr:   begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluOr;   end
                    FnXor:  begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluXor;  end
                    FnNor:  begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluNor;  end
                    FnSlt:  begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluSlt;  end
                    FnSltu: begin reg_write = 1'b1; rt_read = 1'b1; alu_op = AluSltu; end
                    default: ;
                endcase
            end
            OpRegimm: begin
                if (rt == 5'd0) begin
                    branch  = 1'b1;
                    br_cond = BrLtz;
                    alu_op  = AluSub;
                end
            end
            OpJ: jump_imm = 1'b1;
            OpJal: begin
                jump_imm  = 1'b1;
                reg_write = 1'b1;
                link_pc4  = 1'b1;
                dst_d     = 5'd31;
            end
            OpBeq, OpBne: begin
                branch  = 1'b1;
                rt_read = 1'b1;
                br_cond = (op == OpBeq) ? BrEq : BrNe;
                alu_op  = AluSub;
            end
            OpBlez, OpBgtz: begin
                branch  = 1'b1;
                br_cond = (op == OpBlez) ? BrLez : BrGtz;
                alu_op  = AluSub;
            end
            OpAddi:  begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = AluAdd;  end
            OpAddiu: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = AluAddu; end
            OpSlti:  begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = AluSlt;  end
            OpSltiu: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = AluSltu; end
            OpAndi: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                alu_op      = AluAnd;
                imm_zext    = 1'b1;
            end
            OpOri: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                alu_op      = AluOr;
                imm_zext    = 1'b1;
            end
            OpLui: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                alu_op      = AluLui;
                imm_lui     = 1'b1;
            end
            OpLw: begin
                reg_write   = 1'b1;
                mem_read    = 1'b1;
                mem_to_reg  = 1'b1;
                alu_src_imm = 1'b1;
                alu_op      = AluAddu;
            end
            OpSw: begin
                mem_write   = 1'b1;
                alu_src_imm = 1'b1;
                rt_read     = 1'b1;
                alu_op      = AluAddu;
            end
            default: ;
        endcase
    end

    logic [31:0] imm_d;
    logic [15:0] ctrl_d;

    always_comb begin
        if (imm_lui) begin
            imm_d = {imm16, 16'h0000};
        end else if (imm_zext) begin
            imm_d = {16'h0000, imm16};
        end else begin
            imm_d = {{16{imm16[15]}}, imm16};
        end
    end

    assign ctrl_d = {alu_op, br_cond, branch, alu_src_imm, alu_src_shamt, link_pc4,
                     mem_to_reg, mem_write, mem_read, reg_write};

    // ID/EX register.
    logic [31:0] idex_pc4_q, idex_a_q, idex_b_q, idex_imm_q;
    logic [4:0]  idex_shamt_q, idex_rs_q, idex_rt_q, idex_rd_q;
    logic [15:0] idex_ctrl_q;

    // Hazard and jump control.
    logic load_use;
    logic bubble;

    assign load_use = idex_ctrl_q[1] && (idex_rt_q != 5'd0) &&
                      ((idex_rt_q == rs) || ((idex_rt_q == rt) && rt_read));
    assign bubble   = bus_io.Flush || load_use;

    always_comb begin
        bus_io.PCWrite   = 1'b1;
        bus_io.IFIDWrite = 1'b1;
        bus_io.Stall     = 1'b0;
        bus_io.IFFlush   = 1'b0;
        bus_io.PCSrc     = PcSrcSeq;
        if (reset) begin
            // Hold the reset-state controls regardless of what sits on IF/ID.
        end else if (bus_io.Flush) begin
            bus_io.IFFlush = 1'b1;
        end else if (load_use) begin
            bus_io.PCWrite   = 1'b0;
            bus_io.IFIDWrite = 1'b0;
            bus_io.Stall     = 1'b1;
        end else if (jump_imm) begin
            bus_io.PCSrc   = PcSrcJt;
            bus_io.IFFlush = 1'b1;
        end else if (jump_reg) begin
            bus_io.PCSrc   = PcSrcReg;
            bus_io.IFFlush = 1'b1;
        end
    end

    assign bus_io.JT       = instr[25:0];
    assign bus_io.DatabusA = rdata_a;

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            idex_pc4_q   <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_imm_q   <= '0;
            idex_shamt_q <= '0;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_rd_q    <= '0;
            idex_ctrl_q  <= '0;
        end else begin
            idex_pc4_q   <= pc4;
            idex_a_q     <= rdata_a;
            idex_b_q     <= rdata_b;
            idex_imm_q   <= imm_d;
            idex_shamt_q <= shamt;
            idex_rs_q    <= rs;
            idex_rt_q    <= rt;
            idex_rd_q    <= dst_d;
            idex_ctrl_q  <= ctrl_d;
        end
    end

    assign bus_io.IDEX_PC4   = idex_pc4_q;
    assign bus_io.IDEX_A     = idex_a_q;
    assign bus_io.IDEX_B     = idex_b_q;
    assign bus_io.IDEX_Imm   = idex_imm_q;
    assign bus_io.IDEX_Shamt = idex_shamt_q;
    assign bus_io.IDEX_Rs    = idex_rs_q;
    assign bus_io.IDEX_Rt    = idex_rt_q;
    assign bus_io.IDEX_Rd    = idex_rd_q;
    assign bus_io.IDEX_Ctrl  = idex_ctrl_q;

    // Fetch only produces word-aligned PCs within its IMEM_MSB-bit window.
    logic [IMEM_MSB:0] fetch_pc;
    assign fetch_pc = pc4[IMEM_MSB:0];

    assert property (@(posedge clk) disable iff (reset) fetch_pc[1:0] == 2'b00);

endmodule

// File: tb/tb_pipeline_id_idex.sv
// Scoreboard bench for pipeline_id_idex: directed instructions push expectations,
// a negedge monitor matches them against the DUT.
module tb_pipeline_id_idex;

    logic clk;
    logic reset;

    pipeline_id_idex_if bus ();

    pipeline_id_idex dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        SPcWrite, SIfidWrite, SStall, SIfFlush, SPcSrc, SJt, SBusA,
        SPc4, SA, SB, SImm, SRs, SRt, SRd, SCtrl
    } sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] val;
        logic [31:0] mask;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_cnt = 0;
    int   cur = 0;

`ifdef PIPE_WB_BYPASS_EN
    localparam logic [31:0] SameCycleRead = 32'h0000_00AA;
`else
    localparam logic [31:0] SameCycleRead = 32'h0000_0000;
`endif

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [31:0] get_sig(sig_e s);
        case (s)
            SPcWrite:   return {31'd0, bus.PCWrite};
            SIfidWrite: return {31'd0, bus.IFIDWrite};
            SStall:     return {31'd0, bus.Stall};
            SIfFlush:   return {31'd0, bus.IFFlush};
            SPcSrc:     return {29'd0, bus.PCSrc};
            SJt:        return {6'd0, bus.JT};
            SBusA:      return bus.DatabusA;
            SPc4:       return bus.IDEX_PC4;
            SA:         return bus.IDEX_A;
            SB:         return bus.IDEX_B;
            SImm:       return bus.IDEX_Imm;
            SRs:        return {27'd0, bus.IDEX_Rs};
            SRt:        return {27'd0, bus.IDEX_Rt};
            SRd:        return {27'd0, bus.IDEX_Rd};
            default:    return {16'd0, bus.IDEX_Ctrl};
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        int i;
        logic [31:0] got;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].cyc == edge_cnt) begin
                got = get_sig(exp_q[i].sig) & exp_q[i].mask;
                total++;
                if (got !== exp_q[i].val) begin
                    bad++;
                    $display("FAIL %s (cycle %0d): got %h expected %h",
                             exp_q[i].name, edge_cnt, got, exp_q[i].val);
                end
                exp_q.delete(i);
            end else if (exp_q[i].cyc < edge_cnt) begin
                total++;
                bad++;
                $display("FAIL %s: expectation for cycle %0d never checked", exp_q[i].name,
                         exp_q[i].cyc);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc4, input logic rst,
                         input logic flush, input logic wbwe, input logic [4:0] wbrd,
                         input logic [31:0] wbdata);
        @(posedge clk);
        #1;
        cur             = edge_cnt;
        reset           = rst;
        bus.IFID        = {pc4, instr};
        bus.Flush       = flush;
        bus.WBRegWrite  = wbwe;
        bus.WBRd        = wbrd;
        bus.WBData      = wbdata;
    endtask

    task automatic ec(input sig_e s, input logic [31:0] v, input string n);
        exp_q.push_back('{cur, s, v, 32'hFFFF_FFFF, n});
    endtask

    task automatic er(input sig_e s, input logic [31:0] v, input logic [31:0] m,
                      input string n);
        exp_q.push_back('{cur + 1, s, v, m, n});
    endtask

    initial begin
        reset          = 1'b1;
        bus.IFID       = 64'd0;
        bus.Flush      = 1'b0;
        bus.WBRegWrite = 1'b0;
        bus.WBRd       = 5'd0;
        bus.WBData     = 32'd0;

        drive(32'h0000_0000, 32'h100, 1, 0, 0, 5'd0, 32'd0);
        ec(SPcWrite, 1, "reset_pcwrite");
        ec(SIfidWrite, 1, "reset_ifidwrite");
        ec(SStall, 0, "reset_stall");
        ec(SIfFlush, 0, "reset_ifflush");
        ec(SPcSrc, 0, "reset_pcsrc");
        er(SCtrl, 0, 32'hFFFF, "reset_ctrl");

        // add $3,$5,$0 reads $5 after reset; WB $8 <= 0x1234 in the same cycle
        drive(32'h00A0_1820, 32'h104, 0, 0, 1, 5'd8, 32'h1234);
        ec(SBusA, 0, "read_r5_zero");

        // add $9,$8,$8
        drive(32'h0108_4820, 32'h108, 0, 0, 0, 5'd0, 32'd0);
        er(SA, 32'h1234, 32'hFFFF_FFFF, "add_a");
        er(SB, 32'h1234, 32'hFFFF_FFFF, "add_b");
        er(SRd, 9, 32'hFFFF_FFFF, "add_rd");
        er(SCtrl, 16'h0001, 32'h00FF, "add_ctrl");

        // lw $2,0($1)
        drive(32'h8C22_0000, 32'h10C, 0, 0, 0, 5'd0, 32'd0);
        er(SCtrl, 16'h004B, 32'h00FF, "lw_ctrl");
        er(SRt, 2, 32'hFFFF_FFFF, "lw_rt");

        // add $3,$2,$4: load-use stall for exactly one cycle
        drive(32'h0044_1820, 32'h110, 0, 0, 0, 5'd0, 32'd0);
        ec(SPcWrite, 0, "lu_pcwrite");
        ec(SIfidWrite, 0, "lu_ifidwrite");
        ec(SStall, 1, "lu_stall");
        er(SCtrl, 0, 32'hFFFF, "lu_bubble");
        drive(32'h0044_1820, 32'h110, 0, 0, 0, 5'd0, 32'd0);
        ec(SStall, 0, "lu_release_stall");
        ec(SPcWrite, 1, "lu_release_pcwrite");
        er(SCtrl, 16'h0001, 32'h00FF, "lu_add_issue");
        er(SRd, 3, 32'hFFFF_FFFF, "lu_add_rd");

        // jal 0x40
        drive(32'h0C00_0040, 32'h104, 0, 0, 0, 5'd0, 32'd0);
        ec(SPcSrc, 2, "jal_pcsrc");
        ec(SJt, 32'h40, "jal_jt");
        ec(SIfFlush, 1, "jal_ifflush");
        er(SRd, 31, 32'hFFFF_FFFF, "jal_rd");
        er(SPc4, 32'h104, 32'hFFFF_FFFF, "jal_pc4");
        er(SCtrl, 16'h0011, 32'h00FF, "jal_ctrl");

        // lw $5,0($0), then dependent add with Flush
        drive(32'h8C05_0000, 32'h108, 0, 0, 0, 5'd0, 32'd0);
        drive(32'h00A5_3020, 32'h10C, 0, 1, 0, 5'd0, 32'd0);
        ec(SStall, 0, "flush_stall");
        ec(SPcWrite, 1, "flush_pcwrite");
        ec(SIfFlush, 1, "flush_ifflush");
        ec(SPcSrc, 0, "flush_pcsrc");
        er(SCtrl, 0, 32'hFFFF, "flush_bubble");

        // WB $7 <= 0xAA while add $10,$7,$0 reads it
        drive(32'h00E0_5020, 32'h110, 0, 0, 1, 5'd7, 32'hAA);
        ec(SBusA, SameCycleRead, "wb_same_cycle_busa");
        er(SA, SameCycleRead, 32'hFFFF_FFFF, "wb_same_cycle_a");

        // andi $11,$7,0x8001
        drive(32'h30EB_8001, 32'h114, 0, 0, 0, 5'd0, 32'd0);
        er(SImm, 32'h0000_8001, 32'hFFFF_FFFF, "andi_zext");
        er(SRd, 11, 32'hFFFF_FFFF, "andi_rd");
        er(SA, 32'hAA, 32'hFFFF_FFFF, "andi_a_after_wb");

        // addi $12,$0,-1
        drive(32'h200C_FFFF, 32'h118, 0, 0, 0, 5'd0, 32'd0);
        er(SImm, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "addi_sext");
        er(SRd, 12, 32'hFFFF_FFFF, "addi_rd");

        // lui $13,0x1234
        drive(32'h3C0D_1234, 32'h11C, 0, 0, 0, 5'd0, 32'd0);
        er(SImm, 32'h1234_0000, 32'hFFFF_FFFF, "lui_imm");

        // jr $8
        drive(32'h0100_0008, 32'h120, 0, 0, 0, 5'd0, 32'd0);
        ec(SPcSrc, 3, "jr_pcsrc");
        ec(SBusA, 32'h1234, "jr_busa");
        ec(SIfFlush, 1, "jr_ifflush");
        er(SCtrl, 0, 32'h00FF, "jr_ctrl");

        // writes to $0 are dropped
        drive(32'h0000_0820, 32'h124, 0, 0, 1, 5'd0, 32'hDEAD);
        ec(SBusA, 0, "r0_write_same_cycle");
        drive(32'h0000_0820, 32'h128, 0, 0, 0, 5'd0, 32'd0);
        ec(SBusA, 0, "r0_write_next_cycle");

        // reset during a pending load-use stall
        drive(32'h8C22_0000, 32'h12C, 0, 0, 0, 5'd0, 32'd0);
        drive(32'h0044_1820, 32'h130, 1, 0, 0, 5'd0, 32'd0);
        ec(SStall, 0, "rst_mid_stall");
        ec(SPcWrite, 1, "rst_mid_pcwrite");
        er(SCtrl, 0, 32'hFFFF, "rst_mid_ctrl");
        drive(32'h0044_1820, 32'h130, 0, 0, 0, 5'd0, 32'd0);
        ec(SStall, 0, "rst_stall_dropped");
        er(SCtrl, 16'h0001, 32'h00FF, "rst_add_issue");

        // unknown opcode decodes as NOP
        drive(32'hFC00_0000, 32'h134, 0, 0, 0, 5'd0, 32'd0);
        er(SCtrl, 0, 32'hFFFF, "unknown_nop");

        // beq $1,$2,4
        drive(32'h1022_0004, 32'h138, 0, 0, 0, 5'd0, 32'd0);
        ec(SPcSrc, 0, "beq_pcsrc");
        er(SCtrl, 16'h0080, 32'h00FF, "beq_ctrl");
        er(SImm, 32'h4, 32'hFFFF_FFFF, "beq_imm");

        // sw $2,4($1)
        drive(32'hAC22_0004, 32'h13C, 0, 0, 0, 5'd0, 32'd0);
        er(SCtrl, 16'h0044, 32'h00FF, "sw_ctrl");
        er(SRs, 1, 32'hFFFF_FFFF, "sw_rs");

        drive(32'h0000_0000, 32'h140, 0, 0, 0, 5'd0, 32'd0);
        drive(32'h0000_0000, 32'h144, 0, 0, 0, 5'd0, 32'd0);
        @(posedge clk);
        #1;

        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s: expectation left unchecked", exp_q[0].name);
            exp_q.delete(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
